// File: rtl/timer_cmp_multi.sv
// Prescaled timer (free-run or auto-reload) with NUM_CH sticky compare flags; optional TIMER_CAPTURE_EN capture.
// Status/ovf update on the tick edge, irq is a pure register OR; capture lands 3 cycles after cap_in rises; no backpressure.
module timer_cmp_multi #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 4,
   parameter int PRE_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    clr,
   input  logic [PRE_W-1:0]        prescale,
   input  logic                    reload_en,
   input  logic [WIDTH-1:0]        top,
   input  logic [NUM_CH*WIDTH-1:0] cmp_val,
   input  logic [NUM_CH-1:0]       cmp_en,
   input  logic [NUM_CH-1:0]       status_clr,
   input  logic                    cap_in,
   output logic [WIDTH-1:0]        timer,
   output logic [NUM_CH-1:0]       status,
   output logic                    ovf,
   output logic                    irq,
   output logic [WIDTH-1:0]        cap_val,
   output logic                    cap_flag
);

   logic [PRE_W-1:0]  pre_cnt;
   logic              tick;
   logic              at_wrap;
   logic [NUM_CH-1:0] match;

   // clr outranks the tick, so a clearing cycle neither advances nor matches
   assign tick    = en && !clr && (pre_cnt == prescale);
   assign at_wrap = reload_en ? (timer == top) : (timer == {WIDTH{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (clr) begin
         pre_cnt <= '0;
      end else if (en) begin
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
         ovf   <= 1'b0;
      end else if (clr) begin
         timer <= '0;
         ovf   <= 1'b0;
      end else if (tick) begin
         timer <= at_wrap ? '0 : timer + 1'b1;
         if (at_wrap) begin
            ovf <= 1'b1;
         end
      end
   end

   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         match[i] = tick && cmp_en[i] && (timer == cmp_val[i*WIDTH +: WIDTH]);
      end
   end

   // a match in the same cycle as its clear leaves the flag set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status <= '0;
      end else begin
         status <= (status & ~status_clr) | match;
      end
   end

   assign irq = |status;

`ifdef TIMER_CAPTURE_EN
   logic cap_s0;
   logic cap_s1;
   logic cap_s2;
   logic cap_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_s0 <= 1'b0;
         cap_s1 <= 1'b0;
         cap_s2 <= 1'b0;
      end else begin
         cap_s0 <= cap_in;
         cap_s1 <= cap_s0;
         cap_s2 <= cap_s1;
      end
   end

   assign cap_edge = cap_s1 && !cap_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_val  <= '0;
         cap_flag <= 1'b0;
      end else if (cap_edge) begin
         cap_val  <= timer;
         cap_flag <= 1'b1;
      end else if (clr) begin
         cap_flag <= 1'b0;
      end
   end
`else
   logic unused_cap_in;
   assign unused_cap_in = cap_in;
   assign cap_val       = '0;
   assign cap_flag      = 1'b0;
`endif

endmodule

// File: doc/timer_cmp_multi.md
Name: timer_cmp_multi

Overview:
Parametrised free-running timer with a programmable prescaler, optional auto-reload period, and NUM_CH independent compare channels. Each channel has a sticky interrupt status flag. Sits in the timer peripheral and supersedes the single-compare counter. All control and compare inputs come from the peripheral register block, and the aggregated irq goes to the interrupt controller.

Parameters:
WIDTH, 32, counter and compare width in bits
NUM_CH, 4, number of compare channels (1..8)
PRE_W, 8, prescaler width in bits

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  counting enable; prescaler and counter hold when 0
clr  input  1  synchronous clear of counter and prescaler
prescale  input  PRE_W  tick period minus 1 (0 = tick every cycle)
reload_en  input  1  1 = wrap at top; 0 = free-run to 2^WIDTH-1
top  input  WIDTH  auto-reload terminal value
cmp_val  input  NUM_CH*WIDTH  packed compare values, channel i at [i*WIDTH +: WIDTH]
cmp_en  input  NUM_CH  per-channel compare/interrupt enable
status_clr  input  NUM_CH  per-channel write-1 pulse clearing status
timer  output  WIDTH  current counter value
status  output  NUM_CH  sticky match flags
ovf  output  1  sticky wrap flag, cleared by clr
irq  output  1  OR of status bits
cap_in  input  1  capture strobe (used only with TIMER_CAPTURE_EN)
cap_val  output  WIDTH  captured counter value
cap_flag  output  1  capture occurred (sticky, cleared by clr)

Behaviour:
- Reset (rst_n=0, asynchronous): timer=0, prescaler=0, status=0, ovf=0, irq=0, cap_val=0, cap_flag=0.
- Prescaler: counts while en=1. tick=1 in the cycle where prescaler==prescale, and the prescaler returns to 0 on the next edge. Otherwise the prescaler increments. Changing prescale mid-count takes effect on the next compare. If the prescaler already exceeds the new prescale value, it counts up and wraps through 2^PRE_W.
- Counter: advances only on tick.
  - reload_en=1 and timer==top: next value is 0 and ovf is set.
  - reload_en=0 and timer==all-ones: wraps to 0 and ovf is set.
  - Otherwise: timer+1.
  - top=0 with reload_en=1 holds timer at 0 and sets ovf every tick.
- clr has priority over tick. timer and prescaler go to 0 next edge, and ovf and cap_flag clear. status is not affected by clr.
- Compare: channel i matches when tick && cmp_en[i] && timer==cmp_val[i], using the pre-increment value. A match sets status[i] on the same edge the counter advances.
  - One match per counter value. A held counter (en=0) does not re-fire.
- status_clr[i] clears status[i]. If a match and a clear occur in the same cycle, set wins.
- cmp_en[i]=0 blocks new matches but does not clear an existing status[i].
- irq = |status, driven directly from registers, so there is no combinational path from inputs. Latency is 1 cycle from the tick edge to irq.
- en=0: prescaler and counter freeze. status_clr and clr still operate.
- Reset mid-count aborts everything immediately. Counting resumes from 0 after rst_n rises.

Optional Feature:
Macro: TIMER_CAPTURE_EN.
- Defined:
  - cap_in passes through a 2-flop synchroniser (sync reset value 0), followed by rising-edge detection.
  - On a detected edge, cap_val <= timer and cap_flag <= 1.
  - Latency is 3 clk cycles from cap_in rising to cap_flag set.
  - A new edge overwrites cap_val.
  - A capture and clr in the same cycle: capture wins for cap_val and cap_flag.
- Not defined: cap_in is ignored, and cap_val and cap_flag are constant 0. No synchroniser flops are instantiated.

Test Plan:
1. Reset/prescale: rst_n low then high, en=1, prescale=3 -> timer steps 0,1,2 every 4 clk cycles; all outputs 0 during reset.
2. Compare: prescale=0, cmp_val[ch2]=10, cmp_en=4'b0100 -> status=4'b0100 and irq=1 on the edge timer goes 10->11. Pulse status_clr[2] -> status=0 one cycle later. Other channels never set.
3. Auto-reload: reload_en=1, top=5, prescale=0 -> sequence 0..5,0..5. ovf set at the first 5->0 transition. cmp_val[ch0]=5 sets status[0] on each wrap after clearing.
4. Free-run wrap with WIDTH=8 -> 255->0 sets ovf. clr pulse -> timer=0 and ovf=0 next cycle, while status is unchanged.
5. Simultaneous events: match and status_clr in the same cycle -> status stays 1. en=0 while timer==cmp_val -> no re-fire and timer holds. Async reset asserted mid-count -> timer=0 immediately, without waiting for a clk edge.
6. TIMER_CAPTURE_EN defined, timer counting with prescale=0 -> cap_in rises while timer=20 -> cap_flag=1 and cap_val=22 three cycles later. Same bench without the macro -> cap_val=0 and cap_flag=0.
